// File: rtl/bus_pkg.sv
// Shared definitions for the CPU data-bus response path: select bit indices,
// state encoding and default device latencies.
package bus_pkg;

  localparam int unsigned SelW       = 9;
  localparam int unsigned SEL_SRAM   = 0;
  localparam int unsigned SEL_BIOS   = 1;
  localparam int unsigned SEL_VGA    = 2;
  localparam int unsigned SEL_CURSOR = 3;
  localparam int unsigned SEL_TEXT   = 4;
  localparam int unsigned SEL_GRAPH  = 5;
  localparam int unsigned SEL_DRAM   = 6;
  localparam int unsigned SEL_SEG    = 7;
  localparam int unsigned SEL_OTHERS = 8;

  localparam int unsigned LAT_BIOS_DEF  = 1;
  localparam int unsigned LAT_TEXT_DEF  = 1;
  localparam int unsigned LAT_GRAPH_DEF = 2;
  localparam int unsigned LAT_REG_DEF   = 0;
  localparam int unsigned TIMEOUT_DEF   = 255;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } bus_state_e;

  function automatic logic is_handshake(input logic [SelW-1:0] sel);
    return sel[SEL_SRAM] | sel[SEL_DRAM];
  endfunction

endpackage

// File: rtl/bus_resp_collector_if.sv
// CPU request, device read data/acks and CPU response signals of the data bus.
interface bus_resp_collector_if;
  import bus_pkg::*;

  logic            req;
  logic            we;
  logic [SelW-1:0] sel;
  logic [31:0]     rd_sram;
  logic [31:0]     rd_bios;
  logic [31:0]     rd_vga;
  logic [31:0]     rd_cursor;
  logic [31:0]     rd_text;
  logic [31:0]     rd_graph;
  logic [31:0]     rd_dram;
  logic [31:0]     rd_seg;
  logic            sram_ack;
  logic            dram_ack;
  logic [31:0]     cpu_rdata;
  logic            cpu_ready;
  logic            cpu_stall;
  logic            bus_err;

  modport slave (
    input  req, we, sel, rd_sram, rd_bios, rd_vga, rd_cursor, rd_text, rd_graph, rd_dram,
           rd_seg, sram_ack, dram_ack,
    output cpu_rdata, cpu_ready, cpu_stall, bus_err
  );

  modport master (
    output req, we, sel, rd_sram, rd_bios, rd_vga, rd_cursor, rd_text, rd_graph, rd_dram,
           rd_seg, sram_ack, dram_ack,
    input  cpu_rdata, cpu_ready, cpu_stall, bus_err
  );

endinterface

// File: rtl/bus_wait_counter.sv
// 8-bit loadable down-counter shared by the fixed-latency and ack-timeout waits.
module bus_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/bus_resp_collector.sv
// Response collector: latches the device select, waits on fixed latency or ack
// (with timeout) and returns registered read data, ready pulse, stall and error.
module bus_resp_collector
  import bus_pkg::*;
#(
  parameter int unsigned LAT_BIOS  = LAT_BIOS_DEF,
  parameter int unsigned LAT_TEXT  = LAT_TEXT_DEF,
  parameter int unsigned LAT_GRAPH = LAT_GRAPH_DEF,
  parameter int unsigned LAT_REG   = LAT_REG_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input logic                  clk,
  input logic                  rst,
  bus_resp_collector_if.slave  bus
);

  // Counter is loaded with N-1 so the WAIT state exits on the cycle it reads zero.
  localparam logic [7:0] TimeoutLoad = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  bus_state_e      state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic            we_q, we_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            cnt_load, cnt_dec, cnt_zero;
  logic [7:0]      cnt_val;
  logic [7:0]      fixed_lat;
  logic [SelW-1:0] mux_sel;
  logic [31:0]     rd_mux;
  logic            ack_hit;

  // Zero-latency devices are captured in the accept cycle, before sel_q is valid.
  assign mux_sel = (state_q == StIdle) ? bus.sel : sel_q;

  always_comb begin
    rd_mux = ({32{mux_sel[SEL_SRAM]}}   & bus.rd_sram)
           | ({32{mux_sel[SEL_BIOS]}}   & bus.rd_bios)
           | ({32{mux_sel[SEL_VGA]}}    & bus.rd_vga)
           | ({32{mux_sel[SEL_CURSOR]}} & bus.rd_cursor)
           | ({32{mux_sel[SEL_TEXT]}}   & bus.rd_text)
           | ({32{mux_sel[SEL_GRAPH]}}  & bus.rd_graph)
           | ({32{mux_sel[SEL_DRAM]}}   & bus.rd_dram)
           | ({32{mux_sel[SEL_SEG]}}    & bus.rd_seg);
  end

  always_comb begin
    fixed_lat = 8'(LAT_REG);
    if (bus.sel[SEL_BIOS]) begin
      fixed_lat = 8'(LAT_BIOS);
    end else if (bus.sel[SEL_TEXT]) begin
      fixed_lat = 8'(LAT_TEXT);
    end else if (bus.sel[SEL_GRAPH]) begin
      fixed_lat = 8'(LAT_GRAPH);
    end
  end

  assign ack_hit = (sel_q[SEL_SRAM] & bus.sram_ack) | (sel_q[SEL_DRAM] & bus.dram_ack);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_val  = 8'd0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          sel_d = bus.sel;
          we_d  = bus.we;
          if (!$onehot(bus.sel) || bus.sel[SEL_OTHERS]) begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else if (is_handshake(bus.sel)) begin
            state_d  = StWait;
            cnt_load = 1'b1;
            cnt_val  = TimeoutLoad;
          end else if (fixed_lat == 8'd0) begin
            state_d = StResp;
            err_d   = 1'b0;
            rdata_d = bus.we ? 32'd0 : rd_mux;
          end else begin
            state_d  = StWait;
            cnt_load = 1'b1;
            cnt_val  = fixed_lat - 8'd1;
          end
        end
      end
      StWait: begin
        if (is_handshake(sel_q)) begin
          // An ack coinciding with the final timeout cycle still completes cleanly.
          if (ack_hit) begin
            state_d = StResp;
            err_d   = 1'b0;
            rdata_d = we_q ? 32'd0 : rd_mux;
          end else if (cnt_zero) begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            cnt_dec = 1'b1;
          end
        end else if (cnt_zero) begin
          state_d = StResp;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'd0 : rd_mux;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  bus_wait_counter u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign bus.cpu_rdata = rdata_q;
  assign bus.bus_err   = err_q;
  assign bus.cpu_ready = (state_q == StResp);
  assign bus.cpu_stall = ((state_q == StIdle) && bus.req) || (state_q == StWait);

endmodule
